serial_adder: RTL and testbench

Bit-serial multi-bit adder built around a single 1-bit full-adder cell with a registered carry. It accepts two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential stage that consumes the full adder's sum/carry outputs and turns the 1-bit cell into a word-level arithmetic unit.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder used by the serial datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via a + ~b + 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             sub_q;
    logic             start_sub;
    logic             cell_s;
    logic             cell_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign start_sub = sub;
`else
    assign start_sub = 1'b0;
`endif

    full_adder_cell u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0] ^ sub_q),
        .cin (carry_q),
        .s   (cell_s),
        .co  (cell_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign sum_next = {cell_s, {(WIDTH-1){1'b0}}} | (sum_sh >> 1);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        cnt     <= '0;
                        carry_q <= start_sub;
                        sub_q   <= start_sub;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_next;
                    carry_q <= cell_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= sum_next;
                        cout  <= cell_co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with an expected-result queue.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;

    logic [8:0]  sb[$];
    int unsigned total;
    int unsigned passed;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'h00);
        check({tag, "_cout"}, 64'(cout), 64'd0);
    endtask

    // One complete operation; 'hold' cycles of backpressure in DONE with
    // stray in_valid pulses that must be ignored.
    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s, input int hold);
        int n;
        logic [8:0] exp;
        logic [7:0] sum_first;
        logic       cout_first;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        a = x;
        b = y;
        sub_i = s;
        in_valid = 1'b1;
        tick();
        if (s) sb.push_back({1'b0, x} + {1'b0, ~y} + 9'd1);
        else   sb.push_back({1'b0, x} + {1'b0, y});
        check("in_ready_drop", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sub_i = ~s;
            in_valid = n[0];
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'd8);
        check("excl_ready_valid", 64'(in_ready & out_valid), 64'd0);
        sum_first = sum;
        cout_first = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i % 2);
            a = 8'($urandom);
            tick();
            check("bp_sum_stable", 64'(sum), 64'(sum_first));
            check("bp_cout_stable", 64'(cout), 64'(cout_first));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check("sum", 64'(sum), 64'(exp[7:0]));
            check("cout", 64'(cout), 64'(exp[8]));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_rise", 64'(in_ready), 64'd1);
        check("out_valid_fall", 64'(out_valid), 64'd0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub_i = 1'b0;

        tick();
        tick();
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_reset_outputs("rst_idle");
        end

        op(8'h35, 8'h4A, 1'b0, 0);
        check("add_sum_held", 64'(sum), 64'h7F);
        op(8'hFF, 8'h01, 1'b0, 0);
        op(8'hFF, 8'hFF, 1'b0, 0);
        op(8'hA5, 8'h3C, 1'b0, 10);
        check("bp_no_restart", 64'(in_ready), 64'd1);

        // Abort during the fourth RUN cycle.
        a = 8'hFF;
        b = 8'hFF;
        sub_i = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_run");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("rst_after");
        op(8'h10, 8'h20, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        op(8'h20, 8'h05, 1'b1, 0);
        op(8'h05, 8'h20, 1'b1, 0);
        op(8'h80, 8'h80, 1'b1, 2);
`endif
        op(8'h00, 8'h00, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
